// File: rtl/data_gen_inj.sv
// Packet source: header {ID, seq}, running data words and a checksum trailer on an
// AXI-Stream master, with on-demand ID / data / checksum error injection.
module data_gen_inj #(
  parameter int         PACKET_WORD_LEN_BITS = 16,
  parameter int         PACKET_LEN_WORDS     = 12,
  parameter logic [7:0] PACKET_ID            = 8'hAE,
  parameter int         PACKET_PAUSE_TICKS   = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gen_en,
  input  logic                            inj_data_err,
  input  logic                            inj_id_err,
  input  logic                            inj_cs_err,
  output logic [PACKET_WORD_LEN_BITS-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     pkt_cnt,
  output logic [31:0]                     inj_cnt,
  output logic                            busy,
  output logic [1:0]                      dbg_state
);

  // Handshake: a word moves only on a cycle with tvalid && tready. Once tvalid is
  // high, tdata and tlast hold and tvalid stays high until that transfer happens.

  localparam int              W          = PACKET_WORD_LEN_BITS;
  localparam int              N          = PACKET_LEN_WORDS;
  localparam int              IW         = $clog2(N);
  localparam logic [IW-1:0]   CS_IDX     = IW'(N - 1);
  localparam logic [IW-1:0]   DATA0_IDX  = IW'(1);
  localparam logic [W-1:0]    LSB        = W'(1);
  localparam bit              USE_PAUSE  = (PACKET_PAUSE_TICKS >= 2);
  localparam logic [31:0]     PAUSE_LAST = USE_PAUSE ? 32'(PACKET_PAUSE_TICKS - 2) : 32'd0;
  localparam int              F_ID       = 0;
  localparam int              F_DATA     = 1;
  localparam int              F_CS       = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state_q,     state_d;
  logic [W-1:0]  tdata_q,     tdata_d;
  logic          tvalid_q,    tvalid_d;
  logic          tlast_q,     tlast_d;
  logic          busy_q,      busy_d;
  logic [IW-1:0] word_idx_q,  word_idx_d;
  logic [W-1:0]  data_cnt_q,  data_cnt_d;
  logic [W-1:0]  csum_q,      csum_d;
  logic [31:0]   pkt_cnt_q,   pkt_cnt_d;
  logic [31:0]   inj_cnt_q,   inj_cnt_d;
  logic [31:0]   pause_cnt_q, pause_cnt_d;
  logic [2:0]    pend_q,      pend_d;
  logic [2:0]    act_q,       act_d;

  logic [2:0]    inj_req;
  logic          accept;
  logic [IW-1:0] next_idx;
  logic [W-1:0]  sum_next;
  logic [W-9:0]  seq;

  assign inj_req  = {inj_cs_err, inj_data_err, inj_id_err};
  assign accept   = tvalid_q & m_axis_tready;
  assign next_idx = word_idx_q + IW'(1);
  assign sum_next = csum_q + tdata_q;
  assign seq      = (W-8)'(pkt_cnt_q);

  always_comb begin
    state_d     = state_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    word_idx_d  = word_idx_q;
    data_cnt_d  = data_cnt_q;
    csum_d      = csum_q;
    pkt_cnt_d   = pkt_cnt_q;
    inj_cnt_d   = inj_cnt_q;
    pause_cnt_d = pause_cnt_q;
    pend_d      = pend_q | inj_req;
    act_d       = act_q;

    case (state_q)
      ST_IDLE: begin
        if (gen_en) begin
          // A request arriving on this very edge still belongs to this packet.
          act_d      = pend_q | inj_req;
          pend_d     = '0;
          state_d    = ST_SEND;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          word_idx_d = '0;
          csum_d     = '0;
          tdata_d    = {PACKET_ID ^ {8{act_d[F_ID]}}, seq};
        end
      end

      ST_SEND: begin
        if (accept) begin
          if (tlast_q) begin
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            if (|act_q) inj_cnt_d = inj_cnt_q + 32'd1;
            act_d       = '0;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            pause_cnt_d = '0;
            state_d     = USE_PAUSE ? ST_PAUSE : ST_IDLE;
          end else begin
            word_idx_d = next_idx;
            csum_d     = sum_next;
            if (word_idx_q != '0) data_cnt_d = data_cnt_q + W'(1);
            if (next_idx == CS_IDX) begin
              tdata_d = act_q[F_CS] ? (sum_next ^ LSB) : sum_next;
              tlast_d = 1'b1;
            end else begin
              tdata_d = data_cnt_d;
              if (act_q[F_DATA] && next_idx == DATA0_IDX) tdata_d = data_cnt_d ^ LSB;
            end
          end
        end
      end

      ST_PAUSE: begin
        // The IDLE cycle that samples gen_en is the final idle tick of the gap.
        if (pause_cnt_q == PAUSE_LAST) state_d = ST_IDLE;
        else pause_cnt_d = pause_cnt_q + 32'd1;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      word_idx_q  <= '0;
      data_cnt_q  <= '0;
      csum_q      <= '0;
      pkt_cnt_q   <= '0;
      inj_cnt_q   <= '0;
      pause_cnt_q <= '0;
      pend_q      <= '0;
      act_q       <= '0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      word_idx_q  <= word_idx_d;
      data_cnt_q  <= data_cnt_d;
      csum_q      <= csum_d;
      pkt_cnt_q   <= pkt_cnt_d;
      inj_cnt_q   <= inj_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign inj_cnt       = inj_cnt_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule
